// File: rtl/mon_prod_radix.sv
// Iterative radix-2^K Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// One B digit per ADD_A/ADD_M pair, then a single conditional subtraction.
module mon_prod_radix #(
    parameter int WIDTH = 64,
    parameter int K     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic [K-1:0]     mu,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N  = WIDTH / K;
    localparam int CW = $clog2(N + 1);
    localparam int PW = WIDTH + K + 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD_A,
        ADD_M,
        SUB
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, a_n;
    logic [WIDTH-1:0] b_r, b_n;
    logic [WIDTH-1:0] m_r, m_n;
    logic [K-1:0]     mu_r, mu_n;
    logic [K-1:0]     q_r, q_n;
    logic [PW-1:0]    p_r, p_n;
    logic [CW-1:0]    cnt_r, cnt_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;
    logic [WIDTH-1:0] result_r, result_n;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    d_ext;
    logic [PW-1:0]    q_ext;
    logic [PW-1:0]    m_ext;
    logic [PW-1:0]    sum_a;
    logic [PW-1:0]    sum_m;
    logic             p_ge_m;

    assign a_ext  = PW'(a_r);
    assign d_ext  = PW'(b_r[K-1:0]);
    assign q_ext  = PW'(q_r);
    assign m_ext  = PW'(m_r);
    assign sum_a  = p_r + a_ext * d_ext;
    assign sum_m  = p_r + q_ext * m_ext;
    assign p_ge_m = (p_r >= m_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            m_r      <= '0;
            mu_r     <= '0;
            q_r      <= '0;
            p_r      <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            state    <= state_n;
            a_r      <= a_n;
            b_r      <= b_n;
            m_r      <= m_n;
            mu_r     <= mu_n;
            q_r      <= q_n;
            p_r      <= p_n;
            cnt_r    <= cnt_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            result_r <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        a_n      = a_r;
        b_n      = b_r;
        m_n      = m_r;
        mu_n     = mu_r;
        q_n      = q_r;
        p_n      = p_r;
        cnt_n    = cnt_r;
        busy_n   = busy_r;
        done_n   = 1'b0;
        result_n = result_r;
        unique case (state)
            IDLE: begin
                // The done cycle itself is not an accepting cycle.
                if (start && !done_r) begin
                    a_n     = a;
                    b_n     = b;
                    m_n     = m;
                    mu_n    = mu;
                    p_n     = '0;
                    cnt_n   = CW'(N);
                    busy_n  = 1'b1;
                    state_n = ADD_A;
                end
            end
            ADD_A: begin
                p_n     = sum_a;
                q_n     = sum_a[K-1:0] * mu_r;
                state_n = ADD_M;
            end
            ADD_M: begin
                p_n     = sum_m >> K;
                b_n     = b_r >> K;
                cnt_n   = cnt_r - CW'(1);
                state_n = (cnt_r == CW'(1)) ? SUB : ADD_A;
            end
            SUB: begin
                result_n = WIDTH'(p_ge_m ? p_r - m_ext : p_r);
                done_n   = 1'b1;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_mon_prod_radix.sv
// Scoreboard bench for mon_prod_radix: 8-bit directed cases plus
// 64-bit random cases on K=2 and K=4 instances sharing one stimulus.
module tb_mon_prod_radix;

    logic        clk;
    logic        rst;
    logic        start8;
    logic [7:0]  a8, b8, m8;
    logic [1:0]  mu8;
    logic        busy8, done8;
    logic [7:0]  result8;
    logic        start64;
    logic [63:0] a64, b64, m64;
    logic [1:0]  mu2;
    logic [3:0]  mu4;
    logic        busy2, done2, busy4, done4;
    logic [63:0] result2, result4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  q8[$];
    logic [63:0] q2[$];
    logic [63:0] q4[$];

    int   t0_8, t0_2, t0_4;
    int   bc8, bc2, bc4;
    logic bp8, bp2, bp4;
    logic [7:0]  h8;
    logic [63:0] h2, h4;
    int   last8 = -1;
    bit   b2b8 = 0;

    mon_prod_radix #(.WIDTH(8), .K(2)) u8 (
        .clk(clk), .rst(rst), .start(start8),
        .a(a8), .b(b8), .m(m8), .mu(mu8),
        .busy(busy8), .done(done8), .result(result8)
    );

    mon_prod_radix #(.WIDTH(64), .K(2)) u2 (
        .clk(clk), .rst(rst), .start(start64),
        .a(a64), .b(b64), .m(m64), .mu(mu2),
        .busy(busy2), .done(done2), .result(result2)
    );

    mon_prod_radix #(.WIDTH(64), .K(4)) u4 (
        .clk(clk), .rst(rst), .start(start64),
        .a(a64), .b(b64), .m(m64), .mu(mu4),
        .busy(busy4), .done(done4), .result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: reduce a*b mod m, then halve mod m WIDTH times.
    function automatic logic [63:0] mont_ref(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic [63:0] m,
                                             input int w);
        logic [127:0] x;
        x = ({64'b0, a} * {64'b0, b}) % {64'b0, m};
        for (int i = 0; i < w; i++)
            x = x[0] ? (x + {64'b0, m}) >> 1 : x >> 1;
        return x[63:0];
    endfunction

    function automatic logic [7:0] mu_ref(input logic [63:0] m, input int k);
        logic [7:0] mask;
        mask = 8'((1 << k) - 1);
        for (int t = 0; t < (1 << k); t++)
            if (((m[7:0] * 8'(t)) & mask) == mask) return 8'(t);
        return 8'd0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            h8 = '0; bp8 = 1'b0; bc8 = 0;
        end else begin
            if (busy8 && !bp8) t0_8 = cyc - 1;
            if (busy8) bc8++;
            if (done8) begin
                check("w8 done expected", 128'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    check("w8 result", result8, q8.pop_front());
                    check("w8 latency", cyc - t0_8, 10);
                    check("w8 busy cycles", bc8, 9);
                    check("w8 busy low at done", busy8, 0);
                end
                if (b2b8 && last8 >= 0) check("w8 b2b spacing", cyc - last8, 11);
                last8 = cyc; h8 = result8; bc8 = 0;
            end else begin
                check("w8 result hold", result8, h8);
            end
            bp8 = busy8;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            h2 = '0; bp2 = 1'b0; bc2 = 0;
        end else begin
            if (busy2 && !bp2) t0_2 = cyc - 1;
            if (busy2) bc2++;
            if (done2) begin
                check("k2 done expected", 128'(q2.size() != 0), 1);
                if (q2.size() != 0) begin
                    check("k2 result", result2, q2.pop_front());
                    check("k2 latency", cyc - t0_2, 66);
                    check("k2 busy cycles", bc2, 65);
                end
                h2 = result2; bc2 = 0;
            end else begin
                check("k2 result hold", result2, h2);
            end
            bp2 = busy2;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            h4 = '0; bp4 = 1'b0; bc4 = 0;
        end else begin
            if (busy4 && !bp4) t0_4 = cyc - 1;
            if (busy4) bc4++;
            if (done4) begin
                check("k4 done expected", 128'(q4.size() != 0), 1);
                if (q4.size() != 0) begin
                    check("k4 result", result4, q4.pop_front());
                    check("k4 latency", cyc - t0_4, 34);
                    check("k4 busy cycles", bc4, 33);
                end
                h4 = result4; bc4 = 0;
            end else begin
                check("k4 result hold", result4, h4);
            end
            bp4 = busy4;
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e);
        @(negedge clk);
        a8 = a; b8 = b;
        q8.push_back(e);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic op64(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] m);
        logic [7:0] t;
        @(negedge clk);
        a64 = a; b64 = b; m64 = m;
        t = mu_ref(m, 2); mu2 = t[1:0];
        t = mu_ref(m, 4); mu4 = t[3:0];
        q2.push_back(mont_ref(a, b, m, 64));
        q4.push_back(mont_ref(a, b, m, 64));
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q8.size() + q2.size() + q4.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain in budget", 128'(n < budget), 1);
        if (n >= budget) begin
            q8.delete(); q2.delete(); q4.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait8(input bit want_busy, input string tag);
        int n = 0;
        while (!(want_busy ? busy8 : done8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n < 100), 1);
    endtask

    initial begin
        logic [63:0] m, a, b;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; m8 = 8'd13; mu8 = 2'd3;
        start64 = 1'b0; a64 = '0; b64 = '0; m64 = '0; mu2 = '0; mu4 = '0;
        repeat (3) @(negedge clk);
        check("rst busy8", busy8, 0);
        check("rst done8", done8, 0);
        check("rst result8", result8, 0);
        check("rst busy64", {busy2, busy4}, 0);
        check("rst done64", {done2, done4}, 0);
        check("rst result64", {result2, result4}, 0);
        #2 rst = 1'b0;

        op8(8'd5, 8'd7, 8'd1);
        drain(40);
        op8(8'd12, 8'd12, 8'd3);
        drain(40);
        op8(8'd0, 8'd11, 8'd0);
        drain(40);
        op8(8'd12, 8'd11, 8'd6);
        drain(40);

        // Restarts in cycles 3 and 7 of a running operation.
        op8(8'd5, 8'd7, 8'd1);
        repeat (2) @(negedge clk);
        a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'd9; b8 = 8'd2; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain(40);
        repeat (15) @(negedge clk);

        // Reset halfway through the iterations.
        op8(8'd12, 8'd12, 8'd3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy8", busy8, 0);
        check("midrst done8", done8, 0);
        check("midrst result8", result8, 0);
        q8.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        op8(8'd12, 8'd11, 8'd6);
        drain(40);

        // start held high across three operations.
        b2b8 = 1'b1; last8 = -1;
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; q8.push_back(8'd1); start8 = 1'b1;
        wait8(1'b1, "b2b accept 1");
        a8 = 8'd12; b8 = 8'd12; q8.push_back(8'd3);
        wait8(1'b0, "b2b done 1");
        wait8(1'b1, "b2b accept 2");
        a8 = 8'd12; b8 = 8'd11; q8.push_back(8'd6);
        wait8(1'b0, "b2b done 2");
        wait8(1'b1, "b2b accept 3");
        start8 = 1'b0;
        drain(40);
        b2b8 = 1'b0;

        op64(64'd2, 64'd1, 64'd3);
        drain(120);
        m = 64'hFFFF_FFFF_FFFF_FFC5;
        op64(m - 1, m - 1, m);
        drain(120);
        for (int i = 0; i < 30; i++) begin
            m = {$urandom, $urandom} | 64'd1;
            if (m == 64'd1) m = 64'd3;
            a = {$urandom, $urandom} % m;
            b = {$urandom, $urandom} % m;
            op64(a, b, m);
            drain(120);
        end

        check("queues empty", 128'(q8.size() + q2.size() + q4.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mon_prod_radix.md
Name: mon_prod_radix

Overview:
Parametrised iterative Montgomery multiplier computing result = A*B*2^-WIDTH mod M. It scans B one K-bit digit per iteration and performs the final conditional subtraction, so the output is fully reduced.
It uses a start/busy/done handshake and is the modular-multiply engine under the RSA exponentiation controller.
It supersedes the fixed 64-bit, radix-2 Montgomery product unit, which had no reset, no final subtraction and a hard-coded iteration count.

Parameters:
WIDTH, 64, operand/modulus width in bits; must be a multiple of K
K, 2, digit (radix) width in bits; radix = 2^K; 1 <= K <= 8
N (localparam), WIDTH/K, number of iterations
CW (localparam), clog2(N+1), iteration counter width

Ports:
clk     in   1          rising-edge clock
rst     in   1          asynchronous, active-high reset
start   in   1          request; sampled only in IDLE
a       in   WIDTH      multiplicand, required a < m
b       in   WIDTH      multiplier, required b < m
m       in   WIDTH      modulus, odd, m > 1
mu      in   K          precomputed -m^-1 mod 2^K, supplied by host
busy    out  1          high while an operation is in progress
done    out  1          single-cycle pulse when result is valid
result  out  WIDTH      a*b*2^-WIDTH mod m; held until the next done

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, P=0, cnt=0, all operand registers 0.
- Internal accumulator P is WIDTH+K+1 bits. The bound P + a*d + q*m < 2^(K+1)*m guarantees no overflow; every intermediate is computed at this full width.
- States: IDLE, ADD_A, ADD_M, SUB.
- IDLE, start=1 (edge E0):
  - latch a, b, m, mu into A_r, B_r, M_r, MU_r;
  - P<=0, cnt<=N, busy<=1;
  - go to ADD_A.
  - Inputs are not sampled again until the next IDLE.
- ADD_A:
  - d = B_r[K-1:0];
  - P <= P + A_r*d;
  - q <= ((P[K-1:0] + A_r[K-1:0]*d) * MU_r) mod 2^K, computed from pre-update values;
  - go to ADD_M.
- ADD_M:
  - P <= (P + q*M_r) >> K; the low K bits of the sum are zero by construction;
  - B_r <= B_r >> K (zero-filled);
  - cnt <= cnt-1;
  - if cnt==1, go to SUB, else go to ADD_A.
- SUB:
  - result <= (P >= M_r) ? P - M_r : P, truncated to WIDTH;
  - done<=1 for exactly this one cycle; busy<=0;
  - go to IDLE.
- Latency is fixed and data-independent: done is high in the cycle following edge E0 + 2N+1, i.e. 2N+2 cycles after start is sampled. For WIDTH=64, K=2 this is 66 cycles.
- busy rises the cycle after start is sampled and falls in the same edge that raises done.
- start while busy=1 is ignored; it is neither queued nor causes an abort.
- start held high continuously: a new operation is accepted in the first IDLE cycle after done. That gives back-to-back throughput of one result per 2N+3 cycles.
- rst asserted mid-operation: immediate return to the reset values; no done is produced; result is cleared to 0.
- result changes only on the done edge and is stable while busy=1.
- Inputs violating the preconditions (a>=m, b>=m, m even, wrong mu) give an undefined result but an unchanged cycle count and handshake.

Test Plan:
1. WIDTH=8, K=2, m=13, mu=3, a=5, b=7, start pulse -> done exactly 10 cycles after start is sampled; result=1; busy high for 9 cycles.
2. Same config, a=12, b=12 -> result=3. Then a=0, b=11 -> result=0. Then a=12, b=11 -> result=6.
3. WIDTH=64, K=2 and WIDTH=64, K=4: 10,000 random odd m with a,b<m, mu computed by the model -> result matches (a*b*2^-64) mod m. Coverage must show both SUB branches (P>=M and P<M) hit. Latency must be 66 and 34 cycles respectively.
4. Pulse start again at cycles 3 and 7 of a running operation with different operands -> ignored; the original result is returned at the original cycle; exactly one done.
5. Assert rst at iteration N/2 -> busy=0, done=0, result=0 within the same cycle. A fresh start after release -> correct result with full latency.
6. start tied high for 3 operations -> three done pulses spaced 2N+3 cycles apart, each result correct, result stable between pulses.
